api_sched: RTL and testbench
============================

API_SCHED -- requirements
Module: api_sched

Interface
REQ-001 SHALL have parameter TO_MARK, default 32'hbeafbeaf, which is the word pushed to rxfifo on a channel timeout.
REQ-002 SHALL have parameter DROP_W, default 16, which is the width of the dropped-word counter.
REQ-003 SHALL have port clk, input, 1 bit: clock; rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have config inputs: reg_ch_num (6, channel count); reg_word_num (8, words per channel job); reg_timeout (28, WAIT limit in cycles); reg_flush (1, abort).
REQ-005 SHALL have txfifo ports: txfifo_dout (in, 32, FWFT head word); txcnt (in, 11, occupancy); txfifo_pop (out, 1).
REQ-006 SHALL have rxfifo ports: rxfull (in, 1); rxfifo_push (out, 1); rxfifo_din (out, 32).
REQ-007 SHALL have channel outputs: ch_sel (6, selected channel); ch_start (1, job start pulse); ch_tx_vld (1); ch_tx_dat (32).
REQ-008 SHALL have channel inputs: ch_tx_rdy (1); ch_rx_vld (1); ch_rx_dat (32); ch_done (1, job complete pulse).
REQ-009 SHALL have status outputs: reg_state (3, FSM encoding); drop_cnt (DROP_W, rx words dropped).

Function
REQ-010 SHALL implement FSM states IDLE=0, LOAD=1, SEND=2, WAIT=3, NEXT=4, FLUSH=5, with reg_state equal to the current encoding.
REQ-011 IDLE SHALL go to LOAD when reg_ch_num!=0 and reg_word_num!=0, and otherwise SHALL remain in IDLE.
REQ-012 LOAD SHALL wait until txcnt>=reg_word_num, then pulse ch_start for exactly one cycle, load word counter=reg_word_num, and go to SEND.
REQ-013 SEND SHALL drive ch_tx_vld=1 and ch_tx_dat=txfifo_dout (combinational).
REQ-014 In SEND, txfifo_pop SHALL equal ch_tx_vld&ch_tx_rdy, and each pop SHALL decrement the word counter.
REQ-015 SEND SHALL go to WAIT in the cycle after the pop that brings the word counter to 0.
REQ-016 txfifo_pop SHALL never assert outside SEND, and SHALL never assert when txcnt==0.
REQ-017 WAIT SHALL clear the 28-bit timer on entry and increment it every cycle.
REQ-018 In any state except FLUSH, each ch_rx_vld cycle SHALL forward ch_rx_dat to rxfifo_din with rxfifo_push=1 on the next cycle (1-cycle latency).
REQ-019 If rxfull=1 when a word is forwarded, no push SHALL occur and drop_cnt SHALL increment, saturating at all-ones.
REQ-020 WAIT SHALL go to NEXT on ch_done.
REQ-021 WAIT SHALL go to NEXT on timer==reg_timeout and push TO_MARK (subject to rxfull/drop rules); reg_timeout==0 SHALL time out on the first WAIT cycle.
REQ-022 If ch_done and timeout occur in the same cycle, ch_done SHALL win and no TO_MARK SHALL be pushed.
REQ-023 If ch_rx_vld and a TO_MARK push coincide, the data word SHALL be pushed first and TO_MARK in the following cycle, via a one-entry holding register.
REQ-024 NEXT SHALL set ch_sel=ch_sel+1, or 0 if ch_sel+1>=reg_ch_num (this also covers reg_ch_num lowered mid-run), then go to IDLE.
REQ-025 reg_flush=1 in any state SHALL go to FLUSH next cycle and immediately deassert ch_tx_vld, txfifo_pop and ch_start.
REQ-026 FLUSH SHALL discard pending rx words without counting them as drops.
REQ-027 FLUSH SHALL hold while reg_flush=1, then go to IDLE one cycle after reg_flush falls, with ch_sel=0 and the holding register cleared.
REQ-028 Config inputs SHALL be sampled live; a reg_word_num change takes effect at the next LOAD only.

Reset
REQ-029 On rst, the block SHALL enter IDLE with ch_sel=0, counters=0, drop_cnt=0, and all push/pop/vld/start outputs=0.
REQ-030 On rst, rxfifo_din, ch_tx_dat and the timer SHALL be 0.
REQ-031 Reset SHALL abort any job immediately, with no TO_MARK and no pop.

Structure
REQ-032 A shared package api_pkg SHALL hold the state encodings, TO_MARK default, and register field widths (6/8/28/11).
REQ-033 The block SHALL include one sub-module, api_to_timer (28-bit clear/enable counter with compare output).

Verification
REQ-034 Test reg_ch_num=2, word_num=3, txcnt=6, ch_done after 5 cycles: expect 6 pops, ch_sel 0->1->0, and ch_start pulsed twice.
REQ-035 Test reg_timeout=10 with no ch_done: expect 32'hbeafbeaf pushed 11 WAIT cycles after entry, then ch_sel advances.
REQ-036 Test ch_rx_vld=1 (data 32'h11) with rxfull=1 for 3 words: expect drop_cnt=3 and no push; then rxfull=0 with 32'h22 in: expect push of 32'h22.
REQ-037 Test ch_done and timeout in the same cycle: expect no TO_MARK; test ch_rx_vld coinciding with timeout: expect data then TO_MARK on consecutive cycles.
REQ-038 Test reg_flush pulse mid-SEND after 1 of 4 words: expect pops to stop in the same cycle, FLUSH state, IDLE afterwards, and ch_sel=0.
REQ-039 Test txcnt=2 with word_num=3: expect the FSM to stay in LOAD with no pop until txcnt=3.

Source files
------------

// File: rtl/api_pkg.sv
// Shared definitions for the api_sched block: FSM encodings, register
// field widths, the default timeout marker and the rx word record.
package api_pkg;

  localparam int CH_W   = 6;   // channel number / count
  localparam int WORD_W = 8;   // words per channel job
  localparam int TMR_W  = 28;  // WAIT timeout timer
  localparam int CNT_W  = 11;  // txfifo occupancy
  localparam int DAT_W  = 32;

  localparam logic [DAT_W-1:0] TO_MARK_DEF = 32'hbeafbeaf;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_FLUSH = 3'd5;

  // One word heading for the rxfifo.
  typedef struct packed {
    logic             vld;
    logic [DAT_W-1:0] dat;
  } rx_word_t;

endpackage

// File: rtl/api_to_timer.sv
// WAIT-state timeout timer: 28-bit counter with synchronous clear and
// count enable; hit is high while the count equals limit.
// Ports: clk/rst, clr (zero the count), en (count up), limit, hit.
module api_to_timer
  import api_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] limit,
  output logic             hit
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign hit = (count == limit);

endmodule

// File: rtl/api_sched.sv
// Channel job scheduler. For each channel in turn: wait for enough tx
// words, pulse ch_start, stream reg_word_num words from the txfifo to the
// channel, then wait for ch_done or a timeout (which pushes TO_MARK into
// the rxfifo) and advance ch_sel. Channel rx words are forwarded to the
// rxfifo one cycle later; words arriving while rxfull is high are counted
// in drop_cnt. reg_flush aborts to FLUSH and returns to channel 0.
// Ports: config (reg_*), txfifo (txfifo_dout/txcnt/txfifo_pop), rxfifo
// (rxfull/rxfifo_push/rxfifo_din), channel (ch_*), status (reg_state,
// drop_cnt).
module api_sched
  import api_pkg::*;
#(
  parameter logic [DAT_W-1:0] TO_MARK = TO_MARK_DEF,
  parameter int               DROP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   reg_ch_num,
  input  logic [WORD_W-1:0] reg_word_num,
  input  logic [TMR_W-1:0]  reg_timeout,
  input  logic              reg_flush,
  input  logic [DAT_W-1:0]  txfifo_dout,
  input  logic [CNT_W-1:0]  txcnt,
  output logic              txfifo_pop,
  input  logic              rxfull,
  output logic              rxfifo_push,
  output logic [DAT_W-1:0]  rxfifo_din,
  output logic [CH_W-1:0]   ch_sel,
  output logic              ch_start,
  output logic              ch_tx_vld,
  output logic [DAT_W-1:0]  ch_tx_dat,
  input  logic              ch_tx_rdy,
  input  logic              ch_rx_vld,
  input  logic [DAT_W-1:0]  ch_rx_dat,
  input  logic              ch_done,
  output logic [2:0]        reg_state,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [2:0]        state, nxt;
  logic [WORD_W-1:0] wcnt;
  logic              load_go, sending, to_hit, timeout, rx_ok;
  rx_word_t          hold, nhold, fwd;

  // A zero word count would leave SEND with nothing to terminate on, so
  // LOAD only launches a job with a non-zero live reg_word_num.
  assign load_go = (state == ST_LOAD) && !reg_flush && (reg_word_num != '0) &&
                   (txcnt >= {{(CNT_W-WORD_W){1'b0}}, reg_word_num});

  // The FWFT head is only valid while txcnt != 0, so valid is gated on it
  // too; this keeps pop == vld & rdy and never pops an empty fifo.
  assign sending    = (state == ST_SEND) && !reg_flush && (txcnt != '0);
  assign ch_tx_vld  = sending;
  assign ch_tx_dat  = sending ? txfifo_dout : '0;
  assign txfifo_pop = sending && ch_tx_rdy;
  assign ch_start   = load_go;
  assign reg_state  = state;

  // Timer counts only in WAIT and is held at zero elsewhere, so the first
  // WAIT cycle sees 0 and reg_timeout == 0 expires immediately.
  api_to_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .limit (reg_timeout),
    .hit   (to_hit)
  );

  // ch_done beats a same-cycle timeout, so no marker in that case.
  assign timeout = (state == ST_WAIT) && to_hit && !ch_done && !reg_flush;

  always_comb begin
    nxt = state;
    if (reg_flush) nxt = ST_FLUSH;
    else begin
      case (state)
        ST_IDLE:  if (reg_ch_num != '0 && reg_word_num != '0) nxt = ST_LOAD;
        ST_LOAD:  if (load_go) nxt = ST_SEND;
        ST_SEND:  if (txfifo_pop && wcnt == 8'd1) nxt = ST_WAIT;
        ST_WAIT:  if (ch_done || to_hit) nxt = ST_NEXT;
        ST_NEXT:  nxt = ST_IDLE;
        ST_FLUSH: nxt = ST_IDLE;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  // rx ordering: a held word is oldest, then live channel data, then the
  // timeout marker. At most two can compete in one cycle (data+marker in
  // WAIT, or held+data in the NEXT cycle after), so one hold entry is enough.
  assign rx_ok = ch_rx_vld && (state != ST_FLUSH);

  always_comb begin
    fwd   = '0;
    nhold = '0;
    if (state != ST_FLUSH) begin
      if (hold.vld) begin
        fwd = hold;
        if (rx_ok) nhold = '{vld: 1'b1, dat: ch_rx_dat};
      end else if (rx_ok) begin
        fwd = '{vld: 1'b1, dat: ch_rx_dat};
        if (timeout) nhold = '{vld: 1'b1, dat: TO_MARK};
      end else if (timeout) begin
        fwd = '{vld: 1'b1, dat: TO_MARK};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      ch_sel      <= '0;
      hold        <= '0;
      rxfifo_push <= 1'b0;
      rxfifo_din  <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= nxt;
      hold  <= nhold;

      if (load_go)         wcnt <= reg_word_num;
      else if (txfifo_pop) wcnt <= wcnt - 8'd1;

      if (state == ST_FLUSH)
        ch_sel <= '0;
      else if (state == ST_NEXT && !reg_flush)
        ch_sel <= ({1'b0, ch_sel} + 7'd1 >= {1'b0, reg_ch_num}) ? '0 : ch_sel + 6'd1;

      rxfifo_push <= fwd.vld && !rxfull;
      if (fwd.vld && !rxfull) rxfifo_din <= fwd.dat;
      if (fwd.vld && rxfull && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_api_sched.sv
// Directed bench for api_sched: job sequencing, LOAD gating on txcnt,
// timeout marker timing, rx drop counting, done/timeout priority,
// data/marker ordering and flush abort.
module tb_api_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  reg_ch_num;
  logic [7:0]  reg_word_num;
  logic [27:0] reg_timeout;
  logic        reg_flush;
  logic [31:0] txfifo_dout;
  logic [10:0] txcnt;
  logic        txfifo_pop;
  logic        rxfull;
  logic        rxfifo_push;
  logic [31:0] rxfifo_din;
  logic [5:0]  ch_sel;
  logic        ch_start;
  logic        ch_tx_vld;
  logic [31:0] ch_tx_dat;
  logic        ch_tx_rdy;
  logic        ch_rx_vld;
  logic [31:0] ch_rx_dat;
  logic        ch_done;
  logic [2:0]  reg_state;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;
  int start_cnt = 0;
  int p0;

  api_sched #(.TO_MARK(32'hbeafbeaf), .DROP_W(16)) dut (
    .clk(clk), .rst(rst),
    .reg_ch_num(reg_ch_num), .reg_word_num(reg_word_num),
    .reg_timeout(reg_timeout), .reg_flush(reg_flush),
    .txfifo_dout(txfifo_dout), .txcnt(txcnt), .txfifo_pop(txfifo_pop),
    .rxfull(rxfull), .rxfifo_push(rxfifo_push), .rxfifo_din(rxfifo_din),
    .ch_sel(ch_sel), .ch_start(ch_start), .ch_tx_vld(ch_tx_vld),
    .ch_tx_dat(ch_tx_dat), .ch_tx_rdy(ch_tx_rdy), .ch_rx_vld(ch_rx_vld),
    .ch_rx_dat(ch_rx_dat), .ch_done(ch_done), .reg_state(reg_state),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (txfifo_pop) pop_cnt++;
    if (ch_start)   start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      step();
      if (reg_state == s) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    reg_ch_num = '0; reg_word_num = '0; reg_timeout = 28'd1000; reg_flush = 1'b0;
    txfifo_dout = 32'hd0d0_0001; txcnt = '0; rxfull = 1'b0;
    ch_tx_rdy = 1'b1; ch_rx_vld = 1'b0; ch_rx_dat = '0; ch_done = 1'b0;
    #2;
    // reset state
    chk("rst_state", {29'd0, reg_state}, 32'd0);
    chk("rst_sel", {26'd0, ch_sel}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_push", {31'd0, rxfifo_push}, 32'd0);
    chk("rst_pop", {31'd0, txfifo_pop}, 32'd0);
    chk("rst_vld", {31'd0, ch_tx_vld}, 32'd0);
    chk("rst_start", {31'd0, ch_start}, 32'd0);
    chk("rst_din", rxfifo_din, 32'd0);
    chk("rst_txdat", ch_tx_dat, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("idle_cfg0", {29'd0, reg_state}, 32'd0);

    // LOAD holds while txcnt < word_num
    reg_ch_num = 6'd2; reg_word_num = 8'd3; txcnt = 11'd2;
    wait_state(3'd1, 5, "reach_load");
    repeat (3) step();
    chk("load_hold", {29'd0, reg_state}, 32'd1);
    chk("load_nopop", pop_cnt, 32'd0);
    chk("load_nostart", start_cnt, 32'd0);
    txcnt = 11'd3;
    #1 chk("start_pulse", {31'd0, ch_start}, 32'd1);
    step();
    chk("start_one", {31'd0, ch_start}, 32'd0);
    chk("in_send", {29'd0, reg_state}, 32'd2);
    txcnt = 11'd6;

    // two jobs, ch_done 5 cycles into WAIT
    wait_state(3'd3, 10, "job1_wait");
    chk("job1_pops", pop_cnt, 32'd3);
    repeat (4) step();
    ch_done = 1'b1;
    step();
    ch_done = 1'b0;
    chk("job1_next", {29'd0, reg_state}, 32'd4);
    step();
    chk("job1_sel", {26'd0, ch_sel}, 32'd1);
    wait_state(3'd3, 20, "job2_wait");
    reg_word_num = 8'd0;
    repeat (4) step();
    ch_done = 1'b1;
    step();
    ch_done = 1'b0;
    step();
    chk("job2_sel", {26'd0, ch_sel}, 32'd0);
    chk("total_pops", pop_cnt, 32'd6);
    chk("total_starts", start_cnt, 32'd2);
    step();
    chk("parked", {29'd0, reg_state}, 32'd0);

    // timeout = 10: marker pushed 11 cycles after WAIT entry
    reg_timeout = 28'd10; reg_word_num = 8'd3;
    wait_state(3'd3, 20, "to_wait");
    reg_word_num = 8'd0;
    repeat (10) step();
    chk("to_early_push", {31'd0, rxfifo_push}, 32'd0);
    chk("to_early_state", {29'd0, reg_state}, 32'd3);
    step();
    chk("to_push", {31'd0, rxfifo_push}, 32'd1);
    chk("to_mark", rxfifo_din, 32'hbeafbeaf);
    chk("to_next", {29'd0, reg_state}, 32'd4);
    step();
    chk("to_sel", {26'd0, ch_sel}, 32'd1);
    chk("to_single", {31'd0, rxfifo_push}, 32'd0);

    // rx drops while rxfull, then a clean push
    rxfull = 1'b1; ch_rx_vld = 1'b1; ch_rx_dat = 32'h11;
    repeat (3) begin
      step();
      chk("drop_nopush", {31'd0, rxfifo_push}, 32'd0);
    end
    chk("drop_cnt3", {16'd0, drop_cnt}, 32'd3);
    rxfull = 1'b0; ch_rx_dat = 32'h22;
    step();
    ch_rx_vld = 1'b0;
    chk("rx_push", {31'd0, rxfifo_push}, 32'd1);
    chk("rx_din", rxfifo_din, 32'h22);
    step();
    chk("rx_one", {31'd0, rxfifo_push}, 32'd0);
    chk("drop_keep", {16'd0, drop_cnt}, 32'd3);

    // ch_done and timeout in the same cycle: no marker
    reg_timeout = 28'd3; reg_word_num = 8'd3;
    wait_state(3'd3, 20, "dt_wait");
    reg_word_num = 8'd0;
    repeat (3) step();
    ch_done = 1'b1;
    step();
    ch_done = 1'b0;
    chk("dt_next", {29'd0, reg_state}, 32'd4);
    chk("dt_nomark0", {31'd0, rxfifo_push}, 32'd0);
    step();
    chk("dt_nomark1", {31'd0, rxfifo_push}, 32'd0);
    chk("dt_sel", {26'd0, ch_sel}, 32'd0);

    // rx data coinciding with timeout: data then marker
    reg_word_num = 8'd3;
    wait_state(3'd3, 20, "dm_wait");
    reg_word_num = 8'd0;
    repeat (3) step();
    ch_rx_vld = 1'b1; ch_rx_dat = 32'h33;
    step();
    ch_rx_vld = 1'b0;
    chk("dm_push0", {31'd0, rxfifo_push}, 32'd1);
    chk("dm_data", rxfifo_din, 32'h33);
    chk("dm_next", {29'd0, reg_state}, 32'd4);
    step();
    chk("dm_push1", {31'd0, rxfifo_push}, 32'd1);
    chk("dm_mark", rxfifo_din, 32'hbeafbeaf);
    step();
    chk("dm_done", {31'd0, rxfifo_push}, 32'd0);
    chk("dm_sel", {26'd0, ch_sel}, 32'd1);

    // flush after the first of 4 words
    reg_timeout = 28'd1000; reg_word_num = 8'd4;
    wait_state(3'd2, 20, "fl_send");
    p0 = pop_cnt;
    step();
    reg_flush = 1'b1;
    #1;
    chk("fl_pop_now", {31'd0, txfifo_pop}, 32'd0);
    chk("fl_vld_now", {31'd0, ch_tx_vld}, 32'd0);
    chk("fl_one_pop", pop_cnt - p0, 32'd1);
    step();
    chk("fl_state", {29'd0, reg_state}, 32'd5);
    ch_rx_vld = 1'b1; rxfull = 1'b1; ch_rx_dat = 32'h44;
    step();
    ch_rx_vld = 1'b0; rxfull = 1'b0;
    chk("fl_hold", {29'd0, reg_state}, 32'd5);
    chk("fl_nodrop", {16'd0, drop_cnt}, 32'd3);
    chk("fl_nopush", {31'd0, rxfifo_push}, 32'd0);
    chk("fl_pops", pop_cnt - p0, 32'd1);
    reg_flush = 1'b0; reg_word_num = 8'd0;
    step();
    chk("fl_idle", {29'd0, reg_state}, 32'd0);
    chk("fl_sel", {26'd0, ch_sel}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
